// File: rtl/lab3_cache_refill_unit_if.sv
// lab3_cache_refill_unit_if: miss descriptor, memory port and refill bundle of the refill unit.
// The slave modport is the refill unit; the master modport is the cache/memory side.
interface lab3_cache_refill_unit_if #(
  parameter int p_num_words = 4
);
  logic miss_val, miss_rdy, miss_dirty;
  logic [31:0] miss_addr, victim_addr;
  logic [32*p_num_words-1:0] victim_data, refill_data;
  logic memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_data;
  logic memresp_val, memresp_rdy;
  logic [31:0] memresp_data;
  logic refill_val, refill_rdy;
  logic [31:0] refill_addr;
  modport master (
    output miss_val, miss_addr, miss_dirty, victim_addr, victim_data,
    output memreq_rdy, memresp_val, memresp_data, refill_rdy,
    input miss_rdy, memreq_val, memreq_type, memreq_addr, memreq_data,
    input memresp_rdy, refill_val, refill_data, refill_addr
  );
  modport slave (
    input miss_val, miss_addr, miss_dirty, victim_addr, victim_data,
    input memreq_rdy, memresp_val, memresp_data, refill_rdy,
    output miss_rdy, memreq_val, memreq_type, memreq_addr, memreq_data,
    output memresp_rdy, refill_val, refill_data, refill_addr
  );
endinterface

// File: rtl/lab3_cache_refill_unit.sv
// lab3_cache_refill_unit: single-outstanding miss engine; writes back a dirty victim
// word by word, then fetches the missing line and hands it to the cache.
module lab3_cache_refill_unit #(
  parameter int p_num_words = 4
) (
  input logic clk,
  input logic reset,
  lab3_cache_refill_unit_if.slave bus
);
  localparam int cw = $clog2(p_num_words);
  localparam int ow = cw + 2;
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state, state_n;
  logic [cw-1:0] cnt;
  logic [31:ow] vbase, mbase;
  logic [p_num_words-1:0][31:0] vdata, ldata;
  logic last, resp;
  assign last = cnt == cw'(p_num_words - 1);
  assign resp = bus.memresp_val && bus.memresp_rdy;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.miss_val) state_n = bus.miss_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (bus.memreq_rdy) state_n = WB_RESP;
      WB_RESP: if (bus.memresp_val) state_n = last ? RD_REQ : WB_REQ;
      RD_REQ:  if (bus.memreq_rdy) state_n = RD_RESP;
      RD_RESP: if (bus.memresp_val) state_n = last ? DONE : RD_REQ;
      DONE:    if (bus.refill_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // All outputs decode registered state only, so no input reaches an output combinationally
  assign bus.miss_rdy = state == IDLE;
  assign bus.memreq_val = state == WB_REQ || state == RD_REQ;
  assign bus.memreq_type = state == WB_REQ;
  assign bus.memreq_addr = state == WB_REQ ? {vbase, cnt, 2'b00} :
                           state == RD_REQ ? {mbase, cnt, 2'b00} : '0;
  assign bus.memreq_data = state == WB_REQ ? vdata[cnt] : '0;
  assign bus.memresp_rdy = state == WB_RESP || state == RD_RESP;
  assign bus.refill_val = state == DONE;
  assign bus.refill_data = ldata;
  assign bus.refill_addr = {mbase, {ow{1'b0}}};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      vbase <= '0;
      mbase <= '0;
      vdata <= '0;
      ldata <= '0;
    end else begin
      state <= state_n;
      if (bus.miss_val && state == IDLE) begin
        cnt <= '0;
        vbase <= bus.victim_addr[31:ow];
        mbase <= bus.miss_addr[31:ow];
        vdata <= bus.victim_data;
      end
      if (resp) cnt <= last ? '0 : cnt + cw'(1);
      if (resp && state == RD_RESP) ldata[cnt] <= bus.memresp_data;
    end
endmodule

// File: tb/tb_lab3_cache_refill_unit.sv
// tb_lab3_cache_refill_unit: randomized bench against a line-level model of the
// expected memory beat sequence, a word-addressed memory and the refilled line.
module tb_lab3_cache_refill_unit;
  localparam int NW = 4;
  localparam int W = 32 * NW;
  typedef struct {logic t; logic [31:0] a; logic [31:0] d;} req_t;
  typedef struct {logic [31:0] addr; logic dirty; logic [31:0] vaddr; logic [W-1:0] vdata;} miss_t;
  logic clk = 0, reset = 0;
  lab3_cache_refill_unit_if #(.p_num_words(NW)) bus();
  lab3_cache_refill_unit #(.p_num_words(NW)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int ncheck = 0, nbad = 0, cyc = 0, stall = 0, nwr = 0, acc_cyc = 0, rf_cyc = -10, exp_lat = 0;
  bit busy, pending, seen_rf, lat_chk, b2b_chk, rq_hold, rf_hold, do_acc, do_rq, do_rs;
  logic [31:0] resp_word, h_addr, h_data, h_raddr, exp_raddr;
  logic h_type;
  logic [W-1:0] h_rdata, exp_line;
  logic [31:0] mem [logic [31:0]];
  req_t expq[$];
  miss_t mq[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    ncheck++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a * 32'h9E37_79B1 + 32'h1357;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - 32'(a % (4 * NW));
  endfunction

  task automatic push_miss(input logic [31:0] a, input logic d, input logic [31:0] va, input logic [W-1:0] vd);
    miss_t m;
    m.addr = a; m.dirty = d; m.vaddr = va; m.vdata = vd;
    mq.push_back(m);
  endtask

  task automatic drive();
    bus.miss_val = mq.size() != 0;
    if (mq.size() != 0) begin
      bus.miss_addr = mq[0].addr;
      bus.miss_dirty = mq[0].dirty;
      bus.victim_addr = mq[0].vaddr;
      bus.victim_data = mq[0].vdata;
    end
    bus.memreq_rdy = $urandom_range(99) >= stall;
    bus.memresp_val = pending && ($urandom_range(99) >= stall);
    bus.memresp_data = resp_word;
    bus.refill_rdy = $urandom_range(99) >= stall;
  endtask

  task automatic observe();
    miss_t m;
    req_t e;
    logic [31:0] mb, vb;
    do_acc = bus.miss_val && bus.miss_rdy;
    do_rq = bus.memreq_val && bus.memreq_rdy;
    do_rs = bus.memresp_val && bus.memresp_rdy;
    chk("miss_rdy", bus.miss_rdy, !busy);
    chk("resp_rdy_no_req", bus.memresp_rdy && !pending, 0);
    if (rq_hold) begin
      chk("req_hold_val", bus.memreq_val, 1);
      chk("req_hold_addr", bus.memreq_addr, h_addr);
      chk("req_hold_data", bus.memreq_data, h_data);
      chk("req_hold_type", bus.memreq_type, h_type);
    end
    if (rf_hold) begin
      chk("rf_hold_val", bus.refill_val, 1);
      chk("rf_hold_data", bus.refill_data, h_rdata);
      chk("rf_hold_addr", bus.refill_addr, h_raddr);
    end
    if (do_rq) begin
      chk("one_outstanding", pending, 0);
      chk("req_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("req_type", bus.memreq_type, e.t);
        chk("req_addr", bus.memreq_addr, e.a);
        chk("req_data", bus.memreq_data, e.d);
      end
      if (bus.memreq_type) begin
        mem[bus.memreq_addr] = bus.memreq_data;
        nwr++;
        resp_word = $urandom;
      end else resp_word = rd(bus.memreq_addr);
    end
    if (bus.refill_val && !seen_rf) begin
      seen_rf = 1;
      if (lat_chk) chk("latency", cyc - acc_cyc, exp_lat);
    end
    if (bus.refill_val && bus.refill_rdy) begin
      chk("refill_addr", bus.refill_addr, exp_raddr);
      chk("refill_data", bus.refill_data, exp_line);
      chk("beats_left", expq.size(), 0);
      busy = 0;
      rf_cyc = cyc;
    end
    if (do_acc) begin
      m = mq[0];
      if (b2b_chk && rf_cyc >= 0) chk("b2b_gap", cyc - rf_cyc, 1);
      mb = line_of(m.addr);
      vb = line_of(m.vaddr);
      for (int i = 0; i < NW; i++)
        if (m.dirty) expq.push_back('{1'b1, 32'(vb + 4 * i), m.vdata[32*i +: 32]});
      for (int i = 0; i < NW; i++) begin
        expq.push_back('{1'b0, 32'(mb + 4 * i), 32'h0});
        exp_line[32*i +: 32] = (m.dirty && vb == mb) ? m.vdata[32*i +: 32] : rd(32'(mb + 4 * i));
      end
      exp_raddr = mb;
      exp_lat = m.dirty ? 16 : 8;
      busy = 1;
      seen_rf = 0;
      acc_cyc = cyc + 1;
    end
    rq_hold = bus.memreq_val && !bus.memreq_rdy;
    h_addr = bus.memreq_addr;
    h_data = bus.memreq_data;
    h_type = bus.memreq_type;
    rf_hold = bus.refill_val && !bus.refill_rdy;
    h_rdata = bus.refill_data;
    h_raddr = bus.refill_addr;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    if (do_acc) void'(mq.pop_front());
    if (do_rq) pending = 1;
    if (do_rs) pending = 0;
    drive();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((mq.size() != 0 || busy) && n < max) begin
      cycle();
      n++;
    end
    chk("timeout", n < max, 1);
  endtask

  initial begin
    logic [W-1:0] vd;
    int n;
    bus.miss_val = 0; bus.miss_addr = 0; bus.miss_dirty = 0; bus.victim_addr = 0;
    bus.victim_data = 0; bus.memreq_rdy = 0; bus.memresp_val = 0; bus.memresp_data = 0;
    bus.refill_rdy = 0;
    #12;
    chk("rst_miss_rdy", bus.miss_rdy, 1);
    chk("rst_memreq_val", bus.memreq_val, 0);
    chk("rst_memresp_rdy", bus.memresp_rdy, 0);
    chk("rst_refill_val", bus.refill_val, 0);
    chk("rst_memreq_type", bus.memreq_type, 0);
    chk("rst_memreq_addr", bus.memreq_addr, 0);
    chk("rst_memreq_data", bus.memreq_data, 0);
    chk("rst_refill_data", bus.refill_data, 0);
    chk("rst_refill_addr", bus.refill_addr, 0);
    @(posedge clk);
    #1 reset = 1;
    // clean miss with known memory contents
    lat_chk = 1;
    for (int i = 0; i < NW; i++) mem[32'(32'h1230 + 4 * i)] = 32'(32'hA0 + i);
    push_miss(32'h1234, 1'b0, 32'h0, '0);
    drive();
    run_idle(100);
    chk("t1_line", bus.refill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("t1_addr", bus.refill_addr, 32'h1230);
    chk("t1_no_writes", nwr, 0);
    // dirty miss
    push_miss(32'h100, 1'b1, 32'h5000, {32'd4, 32'd3, 32'd2, 32'd1});
    drive();
    run_idle(100);
    chk("t2_writes", nwr, 4);
    chk("t2_wb_last", mem[32'h500C], 4);
    // busy rejection and back-to-back acceptance
    rf_cyc = -10;
    b2b_chk = 1;
    push_miss(32'h2000, 1'b0, 32'h0, '0);
    push_miss(32'h3044, 1'b1, 32'h7010, {$urandom, $urandom, $urandom, $urandom});
    push_miss(32'h7018, 1'b1, 32'h3040, {$urandom, $urandom, $urandom, $urandom});
    drive();
    run_idle(200);
    b2b_chk = 0;
    // reset during the write-back response of word 2
    nwr = 0;
    push_miss(32'h400, 1'b1, 32'h6000, {$urandom, $urandom, $urandom, $urandom});
    drive();
    n = 0;
    while (nwr < 3 && n < 100) begin
      cycle();
      n++;
    end
    chk("rst_reach_wb2", nwr, 3);
    #2 reset = 0;
    #1;
    chk("arst_memreq_val", bus.memreq_val, 0);
    chk("arst_memresp_rdy", bus.memresp_rdy, 0);
    chk("arst_refill_val", bus.refill_val, 0);
    chk("arst_miss_rdy", bus.miss_rdy, 1);
    busy = 0; pending = 0; rq_hold = 0; rf_hold = 0;
    expq.delete();
    mq.delete();
    drive();
    @(posedge clk);
    #1 reset = 1;
    push_miss(32'h0808, 1'b0, 32'h0, '0);
    drive();
    run_idle(100);
    // randomized misses with heavy backpressure
    lat_chk = 0;
    stall = 40;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < NW; i++) vd[32*i +: 32] = $urandom;
      push_miss(32'(32'h1000 + $urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                32'(32'h1000 + $urandom_range(0, 255)), vd);
    end
    drive();
    run_idle(30000);
    $display("test done: total=%0d bad=%0d", ncheck, nbad);
    $finish;
  end
endmodule
